// File: rtl/count_arb_pkg.sv
// rtl/count_arb_pkg.sv - shared types, reset constants and round-robin pick for count_run_arbiter
package count_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  localparam state_t RST_STATE = IDLE;
  localparam int     MAX_N     = 32;
  localparam int     MAX_NW    = 5;

  // One-hot of the first set request at or after ptr, wrapping at n.
  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input int unsigned n,
                                               input int unsigned ptr);
    logic [MAX_N-1:0] pick;
    int unsigned      idx;
    pick = '0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (pick == '0 && req[idx[MAX_NW-1:0]]) pick[idx[MAX_NW-1:0]] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/run_counter.sv
// rtl/run_counter.sv - W-bit up-counter with synchronous clear and enable
module run_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

endmodule

// File: rtl/count_run_arbiter.sv
// rtl/count_run_arbiter.sv - round-robin sequencer of one shared run counter
// Optional owner-abort support: define COUNT_RUN_ARBITER_ABORT_EN.
module count_run_arbiter
  import count_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] len,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic [W-1:0]   count,
  output logic [N-1:0]   done,
  output logic           aborted
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, owner_q, pick_idx;
  logic [W-1:0]     len_q;
  logic [MAX_N-1:0] req_ext, pick_ext;
  logic             clr, en, run_end, owner_drop;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick_ext       = rr_pick(req_ext, N, 32'(ptr_q));
    pick_idx       = '0;
    for (int i = 0; i < MAX_N; i++)
      if (pick_ext[i]) pick_idx = PW'(i);
  end

`ifdef COUNT_RUN_ARBITER_ABORT_EN
  logic abort_q;
  assign owner_drop = !req[owner_q];
  assign aborted    = abort_q;
`else
  assign owner_drop = 1'b0;
  assign aborted    = 1'b0;
`endif

  assign run_end = (count == len_q);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    unique case (state_q)
      IDLE:  if (|req) state_d = GRANT;
      GRANT: begin
        clr     = 1'b1;
        state_d = owner_drop ? DONE : RUN;
      end
      RUN: begin
        // an aborted run stops with the counter frozen where it was
        if (owner_drop || run_end) state_d = DONE;
        else                       en      = 1'b1;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      owner_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req) owner_q <= pick_idx;
      if (state_q == GRANT)        len_q   <= len[owner_q*W +: W];
      if (state_q == DONE)
        ptr_q <= (owner_q == PW'(N-1)) ? '0 : owner_q + 1'b1;
    end
  end

`ifdef COUNT_RUN_ARBITER_ABORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) abort_q <= 1'b0;
    else      abort_q <= (state_q == GRANT || state_q == RUN) && owner_drop;
  end
`endif

  run_counter #(.W(W)) u_run_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .count (count)
  );

  assign busy  = (state_q != IDLE);
  assign grant = busy ? (N'(1) << owner_q) : '0;
  assign done  = (state_q == DONE) ? (N'(1) << owner_q) : '0;

endmodule
